// File: rtl/conv_filter_pkg.sv
// rtl/conv_filter_pkg.sv - shared widths and FSM state type for the convolution engine
package conv_filter_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 15;
    localparam int PROD_W = 64;
    localparam int ACC_W  = 72;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - registered Q16.15 multiply-accumulate with narrowing stage (CONV_SAT_EN selects saturation)
module conv_mac
    import conv_filter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic              last,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic                     unused_frac;

    // Full-width product, window sum including the current tap, then rescale and narrow
    always_comb begin
        prod    = $signed(a) * $signed(b);
        sum     = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        shifted = sum >>> FRAC_W;
`ifdef CONV_SAT_EN
        if (shifted[ACC_W-1] && !(&shifted[ACC_W-2:DATA_W-1])) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
        end else if (!shifted[ACC_W-1] && (|shifted[ACC_W-2:DATA_W-1])) begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            result = shifted[DATA_W-1:0];
        end
`else
        result = shifted[DATA_W-1:0];
`endif
    end

    assign unused_frac = &{1'b0, sum[FRAC_W-1:0], shifted[ACC_W-1:DATA_W]};

    // Accumulator: restarts from zero after the last tap of each window
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= last ? '0 : sum;
        end
    end

endmodule

// File: rtl/conv_filter.sv
// rtl/conv_filter.sv - sequential 2-D valid-mode convolution engine, one MAC per cycle
module conv_filter
    import conv_filter_pkg::*;
#(
    parameter  int FILTER_SIZE = 5,
    parameter  int INPUT_SIZE  = 7,
    parameter  int STRIDE      = 2,
    localparam int OUT_SIZE    = (INPUT_SIZE - FILTER_SIZE) / STRIDE + 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic [FILTER_SIZE*FILTER_SIZE*DATA_W-1:0] filter,
    input  logic [INPUT_SIZE*INPUT_SIZE*DATA_W-1:0]   input_data,
    output logic [OUT_SIZE*OUT_SIZE*DATA_W-1:0]       output_data,
    output logic                                     busy,
    output logic                                     done
);

    localparam int CW = $clog2(INPUT_SIZE + 1);

    state_t state_q, state_d;

    logic [CW-1:0] or_q, oc_q, i_q, j_q;
    logic [FILTER_SIZE*FILTER_SIZE*DATA_W-1:0] filter_q;
    logic [INPUT_SIZE*INPUT_SIZE*DATA_W-1:0]   input_q;
    logic [OUT_SIZE*OUT_SIZE*DATA_W-1:0]       out_q;

    logic              start_ok;
    logic              last_tap;
    logic              last_all;
    logic [DATA_W-1:0] pixel;
    logic [DATA_W-1:0] tap;
    logic [DATA_W-1:0] mac_result;
    int                pix_idx;
    int                tap_idx;
    int                out_idx;

    assign start_ok    = start && (state_q == IDLE);
    assign last_tap    = (i_q == CW'(FILTER_SIZE-1)) && (j_q == CW'(FILTER_SIZE-1));
    assign last_all    = last_tap && (or_q == CW'(OUT_SIZE-1)) && (oc_q == CW'(OUT_SIZE-1));
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign output_data = out_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: DONE is a single-cycle stop on the way back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_all) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand selection from the latched tile and filter for the current tap
    always_comb begin
        pix_idx = (int'(or_q) * STRIDE + int'(i_q)) * INPUT_SIZE + int'(oc_q) * STRIDE + int'(j_q);
        tap_idx = int'(i_q) * FILTER_SIZE + int'(j_q);
        out_idx = int'(or_q) * OUT_SIZE + int'(oc_q);
        pixel   = input_q[pix_idx*DATA_W +: DATA_W];
        tap     = filter_q[tap_idx*DATA_W +: DATA_W];
    end

    conv_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (busy),
        .clear  (start_ok),
        .last   (last_tap),
        .a      (pixel),
        .b      (tap),
        .result (mac_result)
    );

    // Operand latching, nested loop counters (j innermost) and output writeback
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_q     <= '0;
            oc_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
            filter_q <= '0;
            input_q  <= '0;
            out_q    <= '0;
        end else if (start_ok) begin
            or_q     <= '0;
            oc_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
            filter_q <= filter;
            input_q  <= input_data;
        end else if (busy) begin
            if (last_tap) begin
                out_q[out_idx*DATA_W +: DATA_W] <= mac_result;
            end
            if (j_q == CW'(FILTER_SIZE-1)) begin
                j_q <= '0;
                if (i_q == CW'(FILTER_SIZE-1)) begin
                    i_q <= '0;
                    if (oc_q == CW'(OUT_SIZE-1)) begin
                        oc_q <= '0;
                        or_q <= or_q + CW'(1);
                    end else begin
                        oc_q <= oc_q + CW'(1);
                    end
                end else begin
                    i_q <= i_q + CW'(1);
                end
            end else begin
                j_q <= j_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_filter.sv
// tb/tb_conv_filter.sv - self-checking bench for conv_filter against a behavioural convolution model
module tb_conv_filter;

    localparam int F     = 5;
    localparam int N     = 7;
    localparam int S     = 2;
    localparam int O     = (N - F) / S + 1;
    localparam int FF    = F * F;
    localparam int TOTAL = O * O * FF;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [FF*32-1:0]      filter = '0;
    logic [N*N*32-1:0]     input_data = '0;
    logic [O*O*32-1:0]     output_data;
    logic                  busy;
    logic                  done;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    bit cmp_en = 1'b0;

    logic [31:0]       m_f [FF];
    logic [31:0]       m_x [N*N];
    logic              m_busy = 1'b0;
    logic              m_done = 1'b0;
    int                m_cnt = 0;
    logic [O*O*32-1:0] m_out = '0;

    always #5 clk = ~clk;

    conv_filter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .filter      (filter),
        .input_data  (input_data),
        .output_data (output_data),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Correlation of one output window from the latched operands, Q16.15 rescale and narrow
    function automatic logic [31:0] win_res(int w);
        int ro = w / O;
        int co = w % O;
        logic signed [71:0] sum = '0;
        logic signed [71:0] sh;
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic signed [63:0] p;
        for (int i = 0; i < F; i++) begin
            for (int j = 0; j < F; j++) begin
                a   = m_x[(ro*S + i)*N + co*S + j];
                b   = m_f[i*F + j];
                p   = a * b;
                sum = sum + 72'(p);
            end
        end
        sh = sum >>> 15;
`ifdef CONV_SAT_EN
        if (sh > 72'sh7FFFFFFF) return 32'h7FFFFFFF;
        if (sh < -72'sh80000000) return 32'h80000000;
`endif
        return sh[31:0];
    endfunction

    // Reference timeline: window w becomes visible (w+1)*F*F cycles after acceptance
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_out  <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                for (int k = 0; k < FF; k++) m_f[k] <= filter[k*32 +: 32];
                for (int k = 0; k < N*N; k++) m_x[k] <= input_data[k*32 +: 32];
                m_busy <= 1'b1;
                m_cnt  <= 0;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if ((m_cnt + 1) % FF == 0)
                m_out[((m_cnt + 1)/FF - 1)*32 +: 32] <= win_res((m_cnt + 1)/FF - 1);
            if (m_cnt + 1 == TOTAL) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the reference
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 128'(busy), 128'(m_busy));
            chk("done", 128'(done), 128'(m_done));
            chk("output_data", 128'(output_data), 128'(m_out));
            if (done) done_cnt++;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic fill(input logic [31:0] fv, input logic [31:0] xv, input bit odd_only);
        for (int k = 0; k < FF; k++) filter[k*32 +: 32] = (odd_only && k % 2 == 0) ? 32'h0 : fv;
        for (int k = 0; k < N*N; k++) input_data[k*32 +: 32] = (odd_only && k % 2 == 0) ? 32'h0 : xv;
    endtask

    task automatic fill_random(input logic [31:0] mask);
        for (int k = 0; k < FF; k++) filter[k*32 +: 32] = $urandom & mask;
        for (int k = 0; k < N*N; k++) input_data[k*32 +: 32] = $urandom & mask;
    endtask

    task automatic run_and_check(input string nm, input logic [31:0] exp);
        int lat;
        pulse_start();
        wait_done(lat);
        chk({nm, "_latency"}, 128'(lat), 128'(TOTAL));
        for (int w = 0; w < O*O; w++) chk({nm, "_out"}, 128'(output_data[w*32 +: 32]), 128'(exp));
        @(posedge clk); #1;
        chk({nm, "_done_one_cycle"}, 128'(done), 128'(0));
    endtask

    initial begin
        int lat;
        int d0;
        logic [31:0] big_exp;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("reset_out", 128'(output_data), 128'(0));
        chk("reset_busy_done", 128'({busy, done}), 128'(0));
        rst_n = 1'b1;

        fill(32'h00008000, 32'h00008000, 1'b1);
        run_and_check("odd_taps", 32'h00060000);
        fill(32'h00008000, 32'h00008000, 1'b0);
        run_and_check("all_ones", 32'h000C8000);
        fill(32'hFFFF8000, 32'h00008000, 1'b0);
        run_and_check("neg_ones", 32'hFFF38000);
`ifdef CONV_SAT_EN
        big_exp = 32'h7FFFFFFF;
`else
        big_exp = 32'hFFCE0000;
`endif
        fill(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        run_and_check("max_pos", big_exp);

        // Reset in the middle of a run
        fill(32'h00008000, 32'h00008000, 1'b0);
        pulse_start();
        repeat (49) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrun_reset_flags", 128'({busy, done}), 128'(0));
        chk("midrun_reset_out", 128'(output_data), 128'(0));
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (120) @(posedge clk);
        #1;
        chk("midrun_reset_no_done", 128'(done_cnt - d0), 128'(0));

        // Second start and operand changes during a run are ignored
        fill(32'h00008000, 32'h00008000, 1'b0);
        d0 = done_cnt;
        pulse_start();
        repeat (30) @(posedge clk);
        #1 fill_random(32'hFFFFFFFF);
        pulse_start();
        wait_done(lat);
        chk("restart_latency", 128'(lat), 128'(TOTAL - 32));
        for (int w = 0; w < O*O; w++) chk("restart_out", 128'(output_data[w*32 +: 32]), 128'(32'h000C8000));
        repeat (5) @(posedge clk);
        #1;
        chk("restart_single_done", 128'(done_cnt - d0), 128'(1));

        // Randomized tiles, small and full-range operands
        for (int r = 0; r < 8; r++) begin
            fill_random((r % 2 == 0) ? 32'h0003FFFF : 32'hFFFFFFFF);
            if (r == 3) fill_random(32'h80007FFF);
            pulse_start();
            wait_done(lat);
            chk("rand_latency", 128'(lat), 128'(TOTAL));
            if (r == 5) begin
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                chk("start_in_done_ignored", 128'(busy), 128'(0));
            end
            repeat (3) @(posedge clk);
        end

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
